mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares one 4:1 `WIDTH`-bit multiplexer channel between four requesters.
- Samples the four request lines each clock and drives the registered mux select and a one-hot grant.
- Forwards the granted requester's data on `X`.
- Sits in front of the existing 4:1 mux datapath, replacing a free-running or testbench-driven `SEL`.

## Interface
- `WIDTH`, 2: data width of each input and of `X`.
- `MAX_BURST`, 4: maximum consecutive grant cycles for one owner while others wait; legal range ≥1.
- `CLK` input 1: single clock; all state updates on rising edge.
- `RST` input 1: reset, synchronous, active-high.
- `REQ` input 4: request lines; bit i belongs to requester i (0=A, 1=B, 2=C, 3=D).
- `A`, `B`, `C`, `D` input `WIDTH`: requester data.
- `GNT` output 4: registered one-hot grant; all-zero when idle.
- `SEL` output 2: registered binary index of current owner; drives the mux select.
- `BUSY` output 1: registered; high while a grant is held.
- `X` output `WIDTH`: mux output of the owner's data (combinational from `SEL` and `A`–`D`); forced to 0 when `BUSY`=0.

## Operation
- State machine has two states:
  - IDLE: `BUSY`=0.
  - GRANT: `BUSY`=1, owner g = `SEL`.
- Internal registers:
  - `LAST` (2b): last granted index.
  - `CNT`: burst counter, width clog2(`MAX_BURST`+1).
- Winner search: first asserted `REQ` bit in order `LAST`+1, `LAST`+2, `LAST`+3, `LAST` (mod 4).
- IDLE:
  - If `REQ`≠0: grant the winner (set `GNT`/`SEL`, `LAST`=winner), set `CNT`=1, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, `REQ[g]`=0 (release):
  - If other requests are pending: grant the next winner on the same edge (no bubble), `CNT`=1.
  - Otherwise go to IDLE; `GNT`=0, `SEL` holds its value.
- GRANT, `REQ[g]`=1, burst limit reached (see Configuration) and another `REQ` bit set:
  - Rotate to the winner, with search starting from g+1; `CNT`=1.
- GRANT, `REQ[g]`=1, otherwise: hold g; `CNT` increments, saturating at `MAX_BURST`.
- `X` = `A`/`B`/`C`/`D` for `SEL`=0/1/2/3 when `BUSY`=1, else 0.

## Timing
- Reset values (first edge with `RST`=1): state IDLE, `GNT`=0000, `SEL`=00, `BUSY`=0, `LAST`=3 (requester 0 has top priority after reset), `CNT`=0, hence `X`=0.
- `RST` mid-grant aborts the grant on that edge; `REQ` is ignored while `RST`=1.
- Grant latency: `REQ` asserted before edge N → `GNT`/`SEL`/`BUSY` valid after edge N (1 cycle).
- Release latency: owner deasserts `REQ` before edge N → new owner, or idle, after edge N.
- Handover never produces an all-zero `GNT` cycle while any other request is pending.
- `GNT` is always one-hot or zero; `GNT[SEL]`=1 whenever `BUSY`=1.
- Simultaneous requests are resolved purely by the rotating search order, never by fixed index.
- `X` changes in the same cycle as `SEL`/`A`–`D`; there is no register on the data path.

## Configuration
- `MUX_ARB_BURST_LIMIT_EN` defined:
  - An owner is preempted after `MAX_BURST` consecutive grant cycles if any other requester is waiting.
  - With no other requester waiting, it keeps the grant and `CNT` saturates.
- Not defined:
  - No preemption; the owner holds until it drops `REQ`.
  - `MAX_BURST` and `CNT` are unused (the counter may be optimised out).

## Test plan
- Reset: assert `RST` 2 cycles with `REQ`=1111 → `GNT`=0000, `SEL`=00, `BUSY`=0, `X`=00 throughout.
- Single requester, `A`=2'b10: `REQ`=0001 at cycle 0 → `GNT`=0001, `SEL`=00, `X`=10 from cycle 1; drop `REQ` → `BUSY`=0, `X`=00 the next cycle.
- Round-robin with `MUX_ARB_BURST_LIMIT_EN` defined and `MAX_BURST`=4: `REQ`=1111 held → owner sequence 0,1,2,3,0, each for exactly 4 cycles; `SEL` steps 00→01→10→11→00.
- Zero-bubble handover: `REQ`=0101, owner 0 drops at cycle 5 → owner 2 from cycle 6 (`GNT`=0100), `BUSY` stays 1.
- Burst limit disabled (macro undefined): `REQ`=0011 held 20 cycles → `GNT`=0001 all 20 cycles; drop `REQ[0]` → `GNT`=0010 the next cycle.
- Reset mid-grant: owner 2 active, assert `RST` → `GNT`=0000 next cycle; release `RST` with `REQ`=1100 → requester 2 wins, since `LAST`=3 after reset.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter that owns the select of a 4:1 WIDTH-bit mux.
// Four requesters share the channel. GNT, SEL and BUSY are registered. X is
// combinational from SEL and A..D, and is forced to zero while idle.
// Optional feature macro: MUX_ARB_BURST_LIMIT_EN. When it is defined, an owner
// is preempted after MAX_BURST consecutive cycles if another requester waits.
module mux_rr_arbiter #(
   parameter int WIDTH     = 2,
   parameter int MAX_BURST = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [3:0]       REQ,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic [WIDTH-1:0] D,
   output logic [3:0]       GNT,
   output logic [1:0]       SEL,
   output logic             BUSY,
   output logic [WIDTH-1:0] X
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       sel_q, sel_d;
   logic [1:0]       last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [3:0]       others_s;
   logic [1:0]       win_last_s;
   logic [1:0]       win_own_s;
   logic [1:0]       win_s;
   logic             do_grant_s;
   logic             limit_hit_s;

   // First asserted request in the order base+1, base+2, base+3, base (mod 4).
   // The loop runs from the lowest priority to the highest, so the last hit wins.
   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
      logic [1:0] idx;
      logic [1:0] res;
      res = base;
      for (int k = 4; k >= 1; k--) begin
         idx = base + 2'(k);
         if (req[idx]) begin
            res = idx;
         end
      end
      return res;
   endfunction

   assign others_s   = REQ & ~(4'b0001 << sel_q);
   assign win_last_s = rr_pick(REQ, last_q);
   assign win_own_s  = rr_pick(REQ, sel_q);

`ifdef MUX_ARB_BURST_LIMIT_EN
   assign limit_hit_s = (cnt_q == CNT_W'(MAX_BURST));
`else
   assign limit_hit_s = 1'b0;
`endif

   // Next-state logic: decide whether to hold, hand over, rotate or go idle.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      sel_d      = sel_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      do_grant_s = 1'b0;
      win_s      = win_last_s;
      case (state_q)
         ST_IDLE: begin
            if (REQ != 4'b0000) begin
               do_grant_s = 1'b1;
               win_s      = win_last_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (!REQ[sel_q]) begin
               if (others_s != 4'b0000) begin
                  // The owner released while others wait: hand over on the same edge.
                  do_grant_s = 1'b1;
                  win_s      = win_own_s;
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = 4'b0000;
               end
            end else if (limit_hit_s && (others_s != 4'b0000)) begin
               do_grant_s = 1'b1;
               win_s      = win_own_s;
            end else begin
               // The owner keeps the grant; the burst count saturates at MAX_BURST.
               if (cnt_q >= CNT_W'(MAX_BURST)) begin
                  cnt_d = cnt_q;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
         end
      endcase
      if (do_grant_s) begin
         state_d = ST_GRANT;
         gnt_d   = 4'b0001 << win_s;
         sel_d   = win_s;
         last_d  = win_s;
         cnt_d   = CNT_W'(1);
      end else begin
         win_s = win_s;
      end
   end

   // State register. Reset leaves LAST at 3, so requester 0 has top priority.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'b00;
         last_q  <= 2'b11;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign GNT  = gnt_q;
   assign SEL  = sel_q;
   assign BUSY = (state_q == ST_GRANT);

   // Unregistered data path: forward the owner's data, or zero while idle.
   always_comb begin
      X = '0;
      if (BUSY) begin
         case (sel_q)
            2'd0:    X = A;
            2'd1:    X = B;
            2'd2:    X = C;
            2'd3:    X = D;
            default: X = '0;
         endcase
      end else begin
         X = '0;
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized and directed bench for mux_rr_arbiter with an integer reference model.
module tb_mux_rr_arbiter;
   localparam int W  = 2;
   localparam int MB = 4;

   logic         CLK = 1'b0;
   logic         RST;
   logic [3:0]   REQ;
   logic [W-1:0] A, B, C, D;
   logic [3:0]   GNT;
   logic [1:0]   SEL;
   logic         BUSY;
   logic [W-1:0] X;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state. An owner of -1 means idle.
   int m_owner = -1;
   int m_sel   = 0;
   int m_last  = 3;
   int m_cnt   = 0;

   mux_rr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ),
      .A(A), .B(B), .C(C), .D(D),
      .GNT(GNT), .SEL(SEL), .BUSY(BUSY), .X(X)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int pick(input int base, input logic [3:0] req);
      for (int k = 1; k <= 4; k++) begin
         if (req[(base + k) % 4]) return (base + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [W-1:0] data_of(input int i);
      case (i)
         0:       return A;
         1:       return B;
         2:       return C;
         3:       return D;
         default: return '0;
      endcase
   endfunction

   task automatic take(input int w);
      m_owner = w;
      m_sel   = w;
      m_last  = w;
      m_cnt   = 1;
   endtask

   task automatic model_step(input logic rst, input logic [3:0] req);
      logic [3:0] others;
      bit limit_en;
`ifdef MUX_ARB_BURST_LIMIT_EN
      limit_en = 1'b1;
`else
      limit_en = 1'b0;
`endif
      if (rst) begin
         m_owner = -1; m_sel = 0; m_last = 3; m_cnt = 0;
      end else if (m_owner < 0) begin
         if (req != 4'b0000) take(pick(m_last, req));
      end else begin
         others = req;
         others[m_owner] = 1'b0;
         if (!req[m_owner]) begin
            if (others != 4'b0000) take(pick(m_owner, req));
            else m_owner = -1;
         end else if (limit_en && m_cnt == MB && others != 4'b0000) begin
            take(pick(m_owner, req));
         end else if (m_cnt < MB) begin
            m_cnt++;
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [3:0]   eg;
      logic [W-1:0] ex;
      eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      ex = (m_owner >= 0) ? data_of(m_owner) : '0;
      check({tag, ".gnt"},  32'(GNT),  32'(eg));
      check({tag, ".sel"},  32'(SEL),  32'(m_sel));
      check({tag, ".busy"}, 32'(BUSY), 32'(m_owner >= 0));
      check({tag, ".x"},    32'(X),    32'(ex));
   endtask

   // One clock: apply inputs, advance the model at the edge, check on the falling edge.
   task automatic cycle(input logic rst, input logic [3:0] req);
      RST = rst;
      REQ = req;
      @(posedge CLK);
      model_step(rst, req);
      @(negedge CLK);
      check_all("model");
   endtask

   initial begin
      RST = 1'b1; REQ = 4'b0000;
      A = 2'b10; B = 2'b01; C = 2'b11; D = 2'b01;
      @(negedge CLK);

      // Reset with all requests asserted.
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, 4'b1111);
         check("rst.gnt", 32'(GNT), 32'h0);
         check("rst.sel", 32'(SEL), 32'h0);
         check("rst.busy", 32'(BUSY), 32'h0);
         check("rst.x", 32'(X), 32'h0);
      end

      // A single requester, then its release.
      cycle(1'b0, 4'b0001);
      check("single.gnt", 32'(GNT), 32'h1);
      check("single.sel", 32'(SEL), 32'h0);
      check("single.x", 32'(X), 32'h2);
      cycle(1'b0, 4'b0000);
      check("single.idle_busy", 32'(BUSY), 32'h0);
      check("single.idle_x", 32'(X), 32'h0);

      // Zero-bubble handover from owner 0 to owner 2.
      cycle(1'b1, 4'b0000);
      for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0101);
      cycle(1'b0, 4'b0100);
      check("handover.gnt", 32'(GNT), 32'h4);
      check("handover.busy", 32'(BUSY), 32'h1);

      cycle(1'b1, 4'b0000);
`ifdef MUX_ARB_BURST_LIMIT_EN
      // Burst-limited rotation with every requester active.
      for (int k = 1; k <= 20; k++) begin
         cycle(1'b0, 4'b1111);
         check("burst.sel", 32'(SEL), 32'(((k - 1) / 4) % 4));
         check("burst.gnt", 32'(GNT), 32'(4'b0001 << (((k - 1) / 4) % 4)));
      end
`else
      // Without a burst limit the owner holds until it releases.
      for (int k = 1; k <= 20; k++) begin
         cycle(1'b0, 4'b0011);
         check("hold.gnt", 32'(GNT), 32'h1);
      end
      cycle(1'b0, 4'b0010);
      check("hold.release_gnt", 32'(GNT), 32'h2);
`endif

      // Reset mid-grant, then requester 2 wins because LAST is 3 again.
      cycle(1'b1, 4'b0000);
      cycle(1'b0, 4'b0100);
      check("midrst.pre_gnt", 32'(GNT), 32'h4);
      cycle(1'b1, 4'b0100);
      check("midrst.gnt", 32'(GNT), 32'h0);
      cycle(1'b0, 4'b1100);
      check("midrst.win_gnt", 32'(GNT), 32'h4);
      check("midrst.win_sel", 32'(SEL), 32'h2);

      // Random traffic: requests toggle occasionally, with rare resets and changing data.
      for (int n = 0; n < 3000; n++) begin
         logic [3:0] r;
         r = REQ;
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
         end
         A = W'($urandom); B = W'($urandom); C = W'($urandom); D = W'($urandom);
         cycle(($urandom_range(0, 63) == 0), r);
         // The data path has no register, so X follows new data within the cycle.
         A = W'($urandom); B = W'($urandom); C = W'($urandom); D = W'($urandom);
         #1;
         check("comb.x", 32'(X), 32'((m_owner >= 0) ? data_of(m_owner) : '0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
